// File: rtl/sram_pkg.sv
// Shared widths and FSM encoding for the 32 x 8 register-file SRAM controller.
package sram_pkg;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned MEM_DEPTH = 32;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR       = 2'd1,
    S_RD       = 2'd2,
    S_RD_DRAIN = 2'd3
  } state_e;
endpackage

// File: rtl/sram_ctrl.sv
// Burst initiator for the 32 x 8 SRAM: streams write beats into the array and
// read beats out through a one-entry output register with backpressure.
module sram_ctrl
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wr_rd,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_beats;
  logic [ADDR_W-1:0] r_mem_address;
  logic              r_mem_wr_rd;
  logic [DATA_W-1:0] r_mem_data_in;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_rdata_last;
  logic              r_done;

  logic              w_cmd_ready;
  logic              w_rd_hs;
  logic              w_capture;
  logic              w_last_beat;
  logic [ADDR_W-1:0] w_next_addr;

  // No new command while the final write strobe is still on the bus.
  assign w_cmd_ready = (r_state == S_IDLE) && !r_mem_wr_rd;
  assign w_rd_hs     = r_rdata_valid && rdata_ready;
  assign w_capture   = !r_rdata_valid || rdata_ready;
  assign w_last_beat = (r_beats == '0);
  assign w_next_addr = r_addr + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_beats       <= '0;
      r_mem_address <= '0;
      r_mem_wr_rd   <= 1'b0;
      r_mem_data_in <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_rdata_last  <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A consumed beat clears here; a capture in the same cycle overrides below.
      if (w_rd_hs) r_rdata_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_mem_wr_rd <= 1'b0;
          if (cmd_valid && w_cmd_ready) begin
            r_addr        <= cmd_addr;
            r_beats       <= cmd_len;
            r_mem_address <= cmd_addr;
            r_state       <= cmd_wr ? S_WR : S_RD;
          end
        end
        S_WR: begin
          r_mem_wr_rd <= wdata_valid;
          if (wdata_valid) begin
            r_mem_address <= r_addr;
            r_mem_data_in <= wdata;
            r_addr        <= w_next_addr;
            if (w_last_beat) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_beats <= r_beats - 1'b1;
            end
          end
        end
        S_RD: begin
          r_mem_wr_rd <= 1'b0;
          if (w_capture) begin
            r_rdata       <= mem_data_out;
            r_rdata_valid <= 1'b1;
            r_rdata_last  <= w_last_beat;
            r_addr        <= w_next_addr;
            r_mem_address <= w_next_addr;
            if (w_last_beat) r_state <= S_RD_DRAIN;
            else             r_beats <= r_beats - 1'b1;
          end
        end
        S_RD_DRAIN: begin
          r_mem_wr_rd <= 1'b0;
          if (w_rd_hs && r_rdata_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign busy        = !w_cmd_ready;
  assign wdata_ready = (r_state == S_WR);
  assign rdata_valid = r_rdata_valid;
  assign rdata       = r_rdata;
  assign rdata_last  = r_rdata_last;
  assign done        = r_done;
  assign mem_address = r_mem_address;
  assign mem_wr_rd   = r_mem_wr_rd;
  assign mem_data_in = r_mem_data_in;

endmodule
